// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder: recovers per-digit hex values from a multiplexed active-low seven-segment bus
module seven_segment_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int STALE_CYCLES  = 1000000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [6:0]              SEG,
  input  logic [NUM_DIGITS-1:0]   AN,
  output logic [4*NUM_DIGITS-1:0] DIGITS,
  output logic [NUM_DIGITS-1:0]   VALID,
  output logic [NUM_DIGITS-1:0]   ERR,
  output logic                    UPDATE
);
  localparam int W  = 7 + NUM_DIGITS;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(STALE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [W-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0] valid_q, valid_d, err_q, err_d;
  logic [TW-1:0] stale_q [NUM_DIGITS];
  logic [TW-1:0] stale_d [NUM_DIGITS];
  logic update_q, update_d;
  logic [6:0] seg_s;
  logic [NUM_DIGITS-1:0] an_s;
  logic changed, one_hot, capture, legal;
  logic [3:0] nib;
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1a;
      7'b0000011: decode = 5'h1b;
      7'b1000110: decode = 5'h1c;
      7'b0100001: decode = 5'h1d;
      7'b0000110: decode = 5'h1e;
      7'b0001110: decode = 5'h1f;
      default:    decode = 5'h00;
    endcase
  endfunction
  always_comb begin
    sync1_d  = {SEG, AN};
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    seg_s    = sync2_q[W-1 -: 7];
    an_s     = sync2_q[NUM_DIGITS-1:0];
    changed  = sync2_q != prev_q;
    one_hot  = $onehot(~an_s);
    {legal, nib} = decode(seg_s);
    cnt_d    = changed ? '0 : cnt_q == SW'(STABLE_CYCLES) ? cnt_q : cnt_q + SW'(1);
    // entering SETTLE always coincides with a change, so the count restarts from zero
    capture  = state_q == SETTLE && one_hot && cnt_d == SW'(STABLE_CYCLES);
    state_d  = !one_hot ? IDLE :
               (state_q == IDLE || (state_q == HOLD && changed)) ? SETTLE :
               capture ? HOLD : state_q;
    update_d = capture;
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    stale_d  = stale_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits_d[4*i +: 4] = capture && !an_s[i] && legal ? nib : digits_q[4*i +: 4];
      valid_d[i] = capture && !an_s[i] ? legal :
                   valid_q[i] && stale_q[i] + TW'(1) != TW'(STALE_CYCLES);
      err_d[i]   = capture && !an_s[i] ? !legal : err_q[i];
      stale_d[i] = (capture && !an_s[i]) || !valid_q[i] || stale_q[i] + TW'(1) == TW'(STALE_CYCLES) ?
                   '0 : stale_q[i] + TW'(1);
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '1;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      stale_q  <= '{default: '0};
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      stale_q  <= stale_d;
      update_q <= update_d;
    end
  end
  assign DIGITS = digits_q;
  assign VALID  = valid_q;
  assign ERR    = err_q;
  assign UPDATE = update_q;
endmodule
